// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fetch_pkg
// Brief    : Shared encodings, default address map and FSM state type for the
//            instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Memory access-size encodings understood by the byte-array memory
    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_WORD = 2'b10;

    // Default address map
    localparam logic [31:0] DEF_START_PC = 32'h8002_0000;
    localparam logic [31:0] DEF_MEM_BASE = 32'h8002_0000;
    localparam int unsigned DEF_MEM_SIZE = 1048576;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Interface : fetch_unit_if
// Brief     : Memory read port, decode handshake and redirect/fault signals
//             of the fetch unit. master = fetch unit, slave = memory/decode.
// Revision  : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;

    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_writing;
    logic [31:0] mem_data_in;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [31:0] inst_pc;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        fault;
    logic [31:0] fault_pc;

    modport master (
        output mem_address, mem_access_size, mem_writing,
        input  mem_data_in,
        output inst_valid, inst_word, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fault, fault_pc
    );

    modport slave (
        input  mem_address, mem_access_size, mem_writing,
        output mem_data_in,
        input  inst_valid, inst_word, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fault, fault_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_unit_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Brief    : Small FIFO of {pc, word} pairs with a combinational head.
//            Flush wins over push and pop.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [31:0]              push_pc_i,
    input  logic [31:0]              push_word_i,
    output logic [31:0]              head_pc_o,
    output logic [31:0]              head_word_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   word_mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o      = (count_q == (PW+1)'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_pc_o   = pc_mem[rd_ptr_q];
    assign head_word_o = word_mem[rd_ptr_q];

    // A push into a full buffer is only accepted when the head leaves in the same cycle
    always_comb begin
        do_pop   = pop_i & ~empty_o & ~flush_i;
        do_push  = push_i & (~full_o | do_pop) & ~flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr_q]   <= push_pc_i;
            word_mem[wr_ptr_q] <= push_word_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Sequential 32-bit instruction fetcher with credit-based issue,
//            a small instruction buffer, PC redirect and sticky fetch fault.
// Options  : FETCH_PERF_CNT_EN adds saturating perf_fetched/perf_stall outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] START_PC  = DEF_START_PC,
    parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
    parameter int unsigned MEM_SIZE  = DEF_MEM_SIZE,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_stall
`endif
);

    localparam int          CW        = $clog2(BUF_DEPTH);
    localparam logic [31:0] LAST_ADDR = MEM_BASE + MEM_SIZE - 32'd4;

    fetch_state_e state_q, state_d;
    logic [31:0]  next_pc_q, next_pc_d;
    logic [31:0]  mem_address_q, mem_address_d;
    logic         inflight_q, inflight_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic [31:0]  head_pc, head_word;
    logic [CW:0]  buf_count;
    logic         buf_full, buf_empty;
    logic [CW+1:0] occupancy;
    logic         pop_req, credit, illegal;
    logic         push, pop, flush;

    assign pop_req   = ~buf_empty & bus.inst_ready;
    // Slots already spoken for: buffered words plus the response on its way, less the head leaving now
    assign occupancy = {1'b0, buf_count} + (CW+2)'(inflight_q) - (CW+2)'(pop_req);
    // A full buffer never has a request in flight, so only a pop can open a slot
    assign credit    = buf_full ? pop_req : (occupancy < (CW+2)'(BUF_DEPTH));
    // The window check also catches an increment that wrapped past 2^32
    assign illegal   = (next_pc_q[1:0] != 2'b00) | (next_pc_q < MEM_BASE) | (next_pc_q > LAST_ADDR);

    // Next-state, issue, push/pop and fault decisions; redirect outranks everything
    always_comb begin
        state_d       = state_q;
        next_pc_d     = next_pc_q;
        mem_address_d = mem_address_q;
        inflight_d    = 1'b0;
        fault_d       = fault_q;
        fault_pc_d    = fault_pc_q;
        flush         = 1'b0;
        push          = inflight_q;
        pop           = pop_req;
        case (state_q)
            IDLE, FETCH, FULL: begin
                if (bus.redirect_valid) begin
                    flush     = 1'b1;
                    push      = 1'b0;
                    pop       = 1'b0;
                    next_pc_d = bus.redirect_pc;
                    state_d   = FETCH;
                end else if (state_q == IDLE) begin
                    state_d = FETCH;
                end else if (!credit) begin
                    state_d = FULL;
                end else if (illegal) begin
                    fault_d    = 1'b1;
                    fault_pc_d = next_pc_q;
                    state_d    = FAULT;
                end else begin
                    mem_address_d = next_pc_q;
                    next_pc_d     = next_pc_q + 32'd4;
                    inflight_d    = 1'b1;
                    state_d       = FETCH;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            next_pc_q     <= START_PC;
            mem_address_q <= START_PC;
            inflight_q    <= 1'b0;
            fault_q       <= 1'b0;
            fault_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            next_pc_q     <= next_pc_d;
            mem_address_q <= mem_address_d;
            inflight_q    <= inflight_d;
            fault_q       <= fault_d;
            fault_pc_q    <= fault_pc_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (flush),
        .push_pc_i   (mem_address_q),
        .push_word_i (bus.mem_data_in),
        .head_pc_o   (head_pc),
        .head_word_o (head_word),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    assign bus.mem_address     = mem_address_q;
    assign bus.mem_access_size = ACC_WORD;
    assign bus.mem_writing     = 1'b0;
    assign bus.inst_valid      = ~buf_empty;
    assign bus.inst_word       = buf_empty ? 32'd0 : head_word;
    assign bus.inst_pc         = buf_empty ? 32'd0 : head_pc;
    assign bus.fault           = fault_q;
    assign bus.fault_pc        = fault_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_stall_q;

    // Saturating counters of pushed words and decode back-pressure cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && !flush && (perf_fetched_q != 32'hFFFF_FFFF))
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if (!buf_empty && !bus.inst_ready && (perf_stall_q != 32'hFFFF_FFFF))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Self-checking bench for fetch_unit with a combinational memory
//            model and a scoreboard of expected {pc, word} deliveries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h8002_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    fetch_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    // Memory contents: a distinct word for every address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    assign bus.mem_data_in = mem_word(bus.mem_address);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_word(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = mem_word(pc);
        sb.push_back(e);
    endtask

    task automatic apply_reset();
        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        reset_n            = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.mem_address !== START) begin
            n_err++; $display("FAIL reset_addr: got %h, required %h", bus.mem_address, START);
        end
        n_cmp++;
        if ({bus.mem_access_size, bus.mem_writing} !== 3'b100) begin
            n_err++; $display("FAIL reset_size_wr: got %b, required 100", {bus.mem_access_size, bus.mem_writing});
        end
        n_cmp++;
        if ({bus.inst_valid, bus.fault} !== 2'b00) begin
            n_err++; $display("FAIL reset_flags: got %b, required 00", {bus.inst_valid, bus.fault});
        end
        n_cmp++;
        if ({bus.inst_word, bus.inst_pc, bus.fault_pc} !== 96'd0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h, required zeros", bus.inst_word, bus.inst_pc, bus.fault_pc);
        end
    endtask

    task automatic test_sequential();
        exp_t e;
        bus.inst_ready = 1'b1;
        apply_reset();
        for (int k = 0; k < 8; k++) expect_word(START + 32'(4 * k));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 3) begin
                n_cmp++;
                if (bus.mem_address !== START + 32'(4 * (i - 1))) begin
                    n_err++; $display("FAIL seq_addr: got %h, required %h", bus.mem_address, START + 32'(4 * (i - 1)));
                end
            end
            n_cmp++;
            if (bus.inst_valid !== 1'(i >= 2)) begin
                n_err++; $display("FAIL seq_valid: cycle %0d got %b, required %b", i, bus.inst_valid, i >= 2);
            end
            if (bus.inst_valid && bus.inst_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL seq_extra: got pc=%h, required no word", bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_word !== e.word) begin
                        n_err++; $display("FAIL seq_word: got pc=%h word=%h, required pc=%h word=%h", bus.inst_pc, bus.inst_word, e.pc, e.word);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL seq_left: got %0d undelivered, required 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bus.inst_ready = 1'b0;
        apply_reset();
        for (int k = 0; k < 3; k++) expect_word(START + 32'(4 * k));
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.inst_ready = (i >= 12);
            if (i >= 2 && i <= 11) begin
                n_cmp++;
                if (bus.mem_address !== START + 32'd4) begin
                    n_err++; $display("FAIL bp_frozen: cycle %0d got %h, required %h", i, bus.mem_address, START + 32'd4);
                end
                n_cmp++;
                if (bus.inst_valid !== 1'b1 || bus.inst_pc !== START) begin
                    n_err++; $display("FAIL bp_head: got v=%b pc=%h, required v=1 pc=%h", bus.inst_valid, bus.inst_pc, START);
                end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL bp_extra: got pc=%h, required no word", bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_word !== e.word) begin
                        n_err++; $display("FAIL bp_word: got pc=%h word=%h, required pc=%h word=%h", bus.inst_pc, bus.inst_word, e.pc, e.word);
                    end
                end
            end
        end
        bus.inst_ready = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL bp_left: got %0d undelivered, required 0", sb.size());
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        bus.inst_ready = 1'b1;
        apply_reset();
        expect_word(START);
        expect_word(START + 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.redirect_valid = (i == 4);
            bus.redirect_pc    = 32'h8002_0100;
            if (i == 4) begin
                for (int k = 0; k < 3; k++) expect_word(32'h8002_0100 + 32'(4 * k));
            end
            if (i == 5 || i == 6) begin
                n_cmp++;
                if (bus.inst_valid !== 1'b0) begin
                    n_err++; $display("FAIL rd_gap: cycle %0d got valid=%b, required 0", i, bus.inst_valid);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (bus.mem_address !== 32'h8002_0100) begin
                    n_err++; $display("FAIL rd_addr: got %h, required 80020100", bus.mem_address);
                end
            end
            if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL rd_extra: got pc=%h, required no word", bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_word !== e.word) begin
                        n_err++; $display("FAIL rd_word: got pc=%h word=%h, required pc=%h word=%h", bus.inst_pc, bus.inst_word, e.pc, e.word);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL rd_left: got %0d undelivered, required 0", sb.size());
        end
    endtask

    task automatic test_fault_misaligned();
        exp_t e;
        bus.inst_ready = 1'b1;
        apply_reset();
        expect_word(START);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.redirect_valid = (i == 3) || (i == 7);
            bus.redirect_pc    = (i == 3) ? 32'h8002_0102 : START;
            if (i == 4) begin
                n_cmp++;
                if (bus.fault !== 1'b0) begin
                    n_err++; $display("FAIL mis_early: got fault=%b, required 0", bus.fault);
                end
            end
            if (i >= 5) begin
                n_cmp++;
                if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h8002_0102) begin
                    n_err++; $display("FAIL mis_fault: cycle %0d got fault=%b pc=%h, required 1 80020102", i, bus.fault, bus.fault_pc);
                end
                n_cmp++;
                if (bus.mem_address !== START + 32'd8 || bus.inst_valid !== 1'b0) begin
                    n_err++; $display("FAIL mis_noissue: got addr=%h v=%b, required %h 0", bus.mem_address, bus.inst_valid, START + 32'd8);
                end
            end
            if (bus.inst_valid && bus.inst_ready && !(bus.redirect_valid && !bus.fault)) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL mis_extra: got pc=%h, required no word", bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_word !== e.word) begin
                        n_err++; $display("FAIL mis_word: got pc=%h word=%h, required pc=%h word=%h", bus.inst_pc, bus.inst_word, e.pc, e.word);
                    end
                end
            end
        end
        bus.redirect_valid = 1'b0;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL mis_left: got %0d undelivered, required 0", sb.size());
        end
        apply_reset();
        @(negedge clk);
        n_cmp++;
        if (bus.fault !== 1'b0 || bus.fault_pc !== 32'd0) begin
            n_err++; $display("FAIL mis_clear: got fault=%b pc=%h, required 0 0", bus.fault, bus.fault_pc);
        end
    endtask

    task automatic test_range_end();
        exp_t e;
        bus.inst_ready = 1'b1;
        apply_reset();
        expect_word(START);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.redirect_valid = (i == 3);
            bus.redirect_pc    = 32'h8011_FFF0;
            if (i == 3) begin
                for (int k = 0; k < 4; k++) expect_word(32'h8011_FFF0 + 32'(4 * k));
            end
            if (i == 8) begin
                n_cmp++;
                if (bus.fault !== 1'b0) begin
                    n_err++; $display("FAIL end_early: got fault=%b, required 0", bus.fault);
                end
            end
            if (i >= 9) begin
                n_cmp++;
                if (bus.fault !== 1'b1 || bus.fault_pc !== 32'h8012_0000) begin
                    n_err++; $display("FAIL end_fault: cycle %0d got fault=%b pc=%h, required 1 80120000", i, bus.fault, bus.fault_pc);
                end
            end
            if (i >= 10) begin
                n_cmp++;
                if (bus.inst_valid !== 1'b0 || bus.mem_address !== 32'h8011_FFFC) begin
                    n_err++; $display("FAIL end_stop: got v=%b addr=%h, required 0 8011fffc", bus.inst_valid, bus.mem_address);
                end
            end
            if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL end_extra: got pc=%h, required no word", bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_word !== e.word) begin
                        n_err++; $display("FAIL end_word: got pc=%h word=%h, required pc=%h word=%h", bus.inst_pc, bus.inst_word, e.pc, e.word);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL end_left: got %0d undelivered, required 0", sb.size());
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        bus.inst_ready = 1'b1;
        apply_reset();
        repeat (5) @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #2;
        n_cmp++;
        if (bus.mem_address !== START || bus.inst_valid !== 1'b0 || bus.fault !== 1'b0) begin
            n_err++; $display("FAIL ar_ctrl: got addr=%h v=%b f=%b, required %h 0 0", bus.mem_address, bus.inst_valid, bus.fault, START);
        end
        n_cmp++;
        if (bus.inst_pc !== 32'd0 || bus.inst_word !== 32'd0 || bus.fault_pc !== 32'd0) begin
            n_err++; $display("FAIL ar_data: got pc=%h word=%h fpc=%h, required zeros", bus.inst_pc, bus.inst_word, bus.fault_pc);
        end
        #1 reset_n = 1'b1;
        sb.delete();
        for (int k = 0; k < 3; k++) expect_word(START + 32'(4 * k));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                n_cmp++;
                if (bus.mem_address !== START) begin
                    n_err++; $display("FAIL ar_restart: got %h, required %h", bus.mem_address, START);
                end
            end
            if (i < 2) begin
                n_cmp++;
                if (bus.inst_valid !== 1'b0) begin
                    n_err++; $display("FAIL ar_stale: cycle %0d got valid=%b, required 0", i, bus.inst_valid);
                end
            end
            if (bus.inst_valid && bus.inst_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL ar_extra: got pc=%h, required no word", bus.inst_pc);
                end else begin
                    e = sb.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst_word !== e.word) begin
                        n_err++; $display("FAIL ar_word: got pc=%h word=%h, required pc=%h word=%h", bus.inst_pc, bus.inst_word, e.pc, e.word);
                    end
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL ar_left: got %0d undelivered, required 0", sb.size());
        end
    endtask

    initial begin
        n_cmp              = 0;
        n_err              = 0;
        reset_n            = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_fault_misaligned();
        test_range_end();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
